firebird_regfile_sb: RTL and testbench

Parametrised multi-port integer register file with an integrated scoreboard, the successor to the single-cycle regfile for the pipelined core. It provides NRP combinational read ports and NWP synchronous write ports, with x0 hardwired to zero. A busy bit per register tracks in-flight producers: set at issue, cleared at writeback. Decode uses the busy bits for hazard detection. Writeback and issue logic drive the ports directly.

---
 rtl/firebird_regfile_sb.sv | 73 +++++++
 tb/tb_firebird_regfile_sb.sv | 138 +++++++++++++
 2 files changed

// File: rtl/firebird_regfile_sb.sv
// firebird_regfile_sb: multi-port register file with per-register busy scoreboard.
// Define FIREBIRD_RF_BYPASS_EN for same-cycle write/clear forwarding to the read ports.
module firebird_regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NRP  = 2,
  parameter int NWP  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRP*AW-1:0]   raddr,
  output logic [NRP*XLEN-1:0] rdata,
  output logic [NRP-1:0]      rbusy,
  input  logic [NWP-1:0]      we,
  input  logic [NWP*AW-1:0]   waddr,
  input  logic [NWP*XLEN-1:0] wdata,
  input  logic [NWP-1:0]      wb_clr,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic [AW:0]         pend_cnt,
  output logic [NREG-1:0]     busy_vec
);
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     pend_q, pend_d;
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int w = 0; w < NWP; w++) begin
      if (we[w] && waddr[w*AW +: AW] != '0) regs_d[waddr[w*AW +: AW]] = wdata[w*XLEN +: XLEN];
      if (wb_clr[w]) busy_d[waddr[w*AW +: AW]] = 1'b0;
    end
    // set after clears so a new producer outranks a same-cycle writeback
    if (iss_valid) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
    pend_d = '0;
    for (int i = 0; i < NREG; i++) pend_d = pend_d + (AW+1)'(busy_d[i]);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q <= '0;
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      pend_q <= pend_d;
    end
  end
  assign busy_vec = busy_q;
  assign pend_cnt = pend_q;
  genvar r;
  for (r = 0; r < NRP; r++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] rd;
    logic            rb;
    assign a = raddr[r*AW +: AW];
    always_comb begin
      rd = (a == '0) ? '0 : regs_q[a];
      rb = busy_q[a];
`ifdef FIREBIRD_RF_BYPASS_EN
      for (int w = 0; w < NWP; w++) begin
        if (we[w] && waddr[w*AW +: AW] == a && a != '0) rd = wdata[w*XLEN +: XLEN];
        if (wb_clr[w] && waddr[w*AW +: AW] == a) rb = 1'b0;
      end
`endif
    end
    assign rdata[r*XLEN +: XLEN] = reset ? rd : '0;
    assign rbusy[r] = reset & rb;
  end
endmodule

// File: tb/tb_firebird_regfile_sb.sv
// tb_firebird_regfile_sb: directed self-checking bench for firebird_regfile_sb.
module tb_firebird_regfile_sb;
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [1:0]  wb_clr;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [5:0]  pend_cnt;
  logic [31:0] busy_vec;
  int vectors = 0;
  int miscompares = 0;

  firebird_regfile_sb dut (
    .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we(we), .waddr(waddr), .wdata(wdata), .wb_clr(wb_clr),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .pend_cnt(pend_cnt), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = '0; wb_clr = '0; iss_valid = 1'b0; iss_rd = '0; waddr = '0; wdata = '0;
  endtask

  initial begin
    reset = 1'b0; raddr = '0; idle();
    we = 2'b11; waddr = {5'd3, 5'd5}; wdata = {32'h1111_2222, 32'h3333_4444};
    iss_valid = 1'b1; iss_rd = 5'd6; wb_clr = 2'b00;
    repeat (3) step();
    for (int a = 0; a < 32; a++) begin
      raddr = {5'(31 - a), 5'(a)};
      #1 chk("reset_rdata", rdata, 64'h0);
    end
    chk("reset_busy_vec", 64'(busy_vec), 64'h0);
    chk("reset_pend", 64'(pend_cnt), 64'h0);
    chk("reset_rbusy", 64'(rbusy), 64'h0);
    idle();
    reset = 1'b1;
    step();
    chk("after_release_x5", 64'(dut.regs_q[5]), 64'h0);

    we = 2'b11; waddr = {5'd1, 5'd7}; wdata = {32'h0000_000C, 32'h0000_000F};
    step(); idle();
    raddr = {5'd1, 5'd7};
    #1 chk("basic_rd", rdata, {32'h0000_000C, 32'h0000_000F});

    we = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'h0, 32'hFFFF_FFFF};
    step(); idle();
    raddr = {5'd0, 5'd0};
    #1 chk("x0_rd", rdata, 64'h0);

    we = 2'b11; waddr = {5'd5, 5'd5}; wdata = {32'h0000_5555, 32'h0000_AAAA};
    step(); idle();
    raddr = {5'd7, 5'd5};
    #1 chk("collision", rdata, {32'h0000_000F, 32'h0000_5555});

    iss_valid = 1'b1; iss_rd = 5'd3; step();
    chk("iss3_pend", 64'(pend_cnt), 64'd1);
    chk("iss3_busy", 64'(busy_vec), 64'h8);
    iss_rd = 5'd4; step();
    chk("iss4_pend", 64'(pend_cnt), 64'd2);
    chk("iss4_busy", 64'(busy_vec), 64'h18);
    iss_rd = 5'd3; step();
    chk("iss3dup_pend", 64'(pend_cnt), 64'd2);
    chk("iss3dup_busy", 64'(busy_vec), 64'h18);
    idle();
    raddr = {5'd4, 5'd3};
    #1 chk("rbusy_34", 64'(rbusy), 64'b11);
    raddr = {5'd0, 5'd5};
    #1 chk("rbusy_05", 64'(rbusy), 64'b00);

    iss_valid = 1'b1; iss_rd = 5'd3; wb_clr = 2'b01; waddr = {5'd0, 5'd3};
    step(); idle();
    chk("setclr_busy", 64'(busy_vec), 64'h18);
    chk("setclr_pend", 64'(pend_cnt), 64'd2);

    wb_clr = 2'b01; waddr = {5'd0, 5'd4};
    step();
    chk("clr4_pend", 64'(pend_cnt), 64'd1);
    chk("clr4_busy", 64'(busy_vec), 64'h8);
    step(); idle();
    chk("clr_idle_pend", 64'(pend_cnt), 64'd1);

    wb_clr = 2'b10; waddr = {5'd3, 5'd0};
    step(); idle();
    chk("clr3_p1_pend", 64'(pend_cnt), 64'd0);
    chk("clr3_p1_busy", 64'(busy_vec), 64'h0);

    we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'hDEAD_BEEF}; raddr = {5'd0, 5'd9};
`ifdef FIREBIRD_RF_BYPASS_EN
    #1 chk("bypass_pre", 64'(rdata[31:0]), 64'hDEAD_BEEF);
`else
    #1 chk("bypass_pre", 64'(rdata[31:0]), 64'h0);
`endif
    step(); idle();
    #1 chk("bypass_post", 64'(rdata[31:0]), 64'hDEAD_BEEF);

    we = 2'b01; waddr = {5'd0, 5'd2}; wdata = {32'h0, 32'h0000_1234};
    iss_valid = 1'b1; iss_rd = 5'd2;
    step(); idle();
    raddr = {5'd9, 5'd2};
    #1 chk("pre_arst_rd", rdata, {32'hDEAD_BEEF, 32'h0000_1234});
    chk("pre_arst_busy", 64'(busy_vec), 64'h4);
    chk("pre_arst_pend", 64'(pend_cnt), 64'd1);
    chk("pre_arst_rbusy", 64'(rbusy), 64'b01);
    #1 reset = 1'b0;
    #1 chk("arst_rd", rdata, 64'h0);
    chk("arst_busy", 64'(busy_vec), 64'h0);
    chk("arst_pend", 64'(pend_cnt), 64'd0);
    chk("arst_rbusy", 64'(rbusy), 64'b00);
    reset = 1'b1;
    step();
    chk("post_arst_rd", rdata, 64'h0);
    chk("post_arst_pend", 64'(pend_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
